// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: round-robin arbiter that shares one register bus among
// N_REQ register managers, stalls reads that would overtake a pending write
// to the same address, and aborts bus transfers that never get acknowledged.
module reg_bus_arbiter #(
    parameter int N_REQ     = 4,
    parameter int ADDR_SIZE = 32,
    parameter int DATA_SIZE = 32,
    parameter int TMO       = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_read,
    input  logic [N_REQ-1:0]           req_write,
    input  logic [N_REQ*ADDR_SIZE-1:0] req_addr,
    input  logic [N_REQ*DATA_SIZE-1:0] req_wdata,
    output logic [N_REQ-1:0]           grant,
    output logic [N_REQ-1:0]           done,
    output logic [DATA_SIZE-1:0]       rdata,
    output logic                       err,
    output logic [N_REQ-1:0]           rw_halt,
    output logic                       is_bus_busy,
    output logic [ADDR_SIZE-1:0]       mem_addr,
    output logic [DATA_SIZE-1:0]       mem_wdata,
    output logic                       mem_read,
    output logic                       mem_write,
    input  logic                       mem_ack,
    input  logic [DATA_SIZE-1:0]       mem_rdata
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (TMO > 1) ? $clog2(TMO + 1) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]           state;
    logic [PW-1:0]        ptr;
    logic [PW-1:0]        owner;
    logic [PW-1:0]        next_ptr;
    logic [CW-1:0]        wait_cnt;
    logic [N_REQ-1:0]     eligible;
    logic [N_REQ-1:0]     owner_onehot;
    logic [PW-1:0]        pick;
    logic                 pick_valid;
    logic [ADDR_SIZE-1:0] pick_addr;
    logic [DATA_SIZE-1:0] pick_wdata;
    logic                 timeout_hit;
    int                   idx;

    // A read is held back while any other channel wants to write the same address
    always_comb begin
        rw_halt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (i != j && req_read[i] && req_write[j] &&
                    req_addr[i*ADDR_SIZE +: ADDR_SIZE] == req_addr[j*ADDR_SIZE +: ADDR_SIZE]) begin
                    rw_halt[i] = 1'b1;
                end
            end
        end
    end

    assign eligible = req_write | (req_read & ~rw_halt);

    // Round-robin pick: scanning downward lets the channel nearest ptr overwrite the rest
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        idx        = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (eligible[idx]) begin
                pick       = PW'(idx);
                pick_valid = 1'b1;
            end
        end
        pick_addr  = req_addr[int'(pick)*ADDR_SIZE +: ADDR_SIZE];
        pick_wdata = req_wdata[int'(pick)*DATA_SIZE +: DATA_SIZE];
    end

    // Decode the owner index into the one-hot form used by grant and done
    always_comb begin
        owner_onehot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            owner_onehot[i] = (owner == PW'(i));
        end
    end

    assign next_ptr    = (owner == PW'(N_REQ - 1)) ? '0 : owner + PW'(1);
    assign timeout_hit = (state == ST_WAIT) && !mem_ack && (wait_cnt == CW'(TMO - 1));
    assign is_bus_busy = (state != ST_IDLE);
    assign grant       = is_bus_busy ? owner_onehot : '0;
    assign done        = (state == ST_DONE) ? owner_onehot : '0;

    // Transaction FSM: latch the winner, strobe the bus once, wait for ack or timeout
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            owner     <= '0;
            wait_cnt  <= '0;
            err       <= 1'b0;
            rdata     <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            err       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state     <= ST_ISSUE;
                        owner     <= pick;
                        mem_write <= req_write[pick];
                        mem_read  <= ~req_write[pick];
                        mem_addr  <= pick_addr;
                        mem_wdata <= pick_wdata;
                    end
                end
                ST_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mem_ack) begin
                        rdata <= mem_rdata;
                        state <= ST_DONE;
                    end else if (timeout_hit) begin
                        rdata <= '0;
                        err   <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    ptr   <= next_ptr;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb_reg_bus_arbiter: directed scenarios for the register bus arbiter with a
// small memory responder on the bus side.
module tb_reg_bus_arbiter;

    localparam int N   = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 255;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_read, req_write;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    grant, done, rw_halt;
    logic [DW-1:0]   rdata, mem_wdata, mem_rdata;
    logic [AW-1:0]   mem_addr;
    logic            err, is_bus_busy, mem_read, mem_write, mem_ack;

    int   checks = 0;
    int   errors = 0;
    bit   never_ack = 1'b0;
    bit   last_write = 1'b0;
    logic [31:0] mem [0:255];

    reg_bus_arbiter #(.N_REQ(N), .ADDR_SIZE(AW), .DATA_SIZE(DW), .TMO(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_read(req_read), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .grant(grant), .done(done), .rdata(rdata), .err(err),
        .rw_halt(rw_halt), .is_bus_busy(is_bus_busy),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    initial forever #5 clk = ~clk;

    // Memory responder: takes the strobe seen in ISSUE and acks in the first WAIT cycle
    initial begin : responder
        bit         pend;
        logic [7:0] ra;
        pend      = 1'b0;
        ra        = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (!rst) begin
                pend = 1'b0;
            end else if (pend) begin
                pend = 1'b0;
                if (!never_ack) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem[ra];
                end
            end else if (mem_read || mem_write) begin
                ra         = mem_addr[7:0];
                last_write = mem_write;
                if (mem_write) mem[ra] = mem_wdata;
                pend = 1'b1;
            end
        end
    end

    task automatic set_chan(input int ch, input logic [31:0] a, input logic [31:0] d);
        req_addr[ch*AW +: AW]  = a;
        req_wdata[ch*DW +: DW] = d;
    endtask

    task automatic wait_done(input int limit);
        int cyc;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (done === '0 && cyc < limit);
    endtask

    task automatic test_reset();
        rst = 1'b0; req_read = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        checks++; if (grant !== 4'b0) begin errors++; $display("[TB] FAIL reset_grant: got %b expected 0000", grant); end
        checks++; if (done !== 4'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0000", done); end
        checks++; if ({err, is_bus_busy, mem_read, mem_write} !== 4'b0) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 0000", {err, is_bus_busy, mem_read, mem_write}); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata: got %h expected 0", rdata); end
        checks++; if ({mem_addr, mem_wdata} !== 64'h0) begin errors++; $display("[TB] FAIL reset_bus: got %h expected 0", {mem_addr, mem_wdata}); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (is_bus_busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_no_req: got %b expected 0", is_bus_busy); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_seq [5];
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < N; i++) set_chan(i, 32'h40 + i, 32'h1000 + i);
        req_write = 4'hF;
        for (int n = 0; n < 5; n++) begin
            wait_done(20);
            checks++; if (done !== exp_seq[n]) begin errors++; $display("[TB] FAIL rr_order_%0d: got %b expected %b", n, done, exp_seq[n]); end
            req_write = req_write & ~done;
            if (n == 1) begin
                set_chan(0, 32'h44, 32'h2000);
                req_write[0] = 1'b1;
            end
        end
        req_write = '0;
        for (int i = 0; i < N; i++) begin
            checks++; if (mem[8'h40 + i] !== 32'h1000 + i) begin errors++; $display("[TB] FAIL rr_mem_%0d: got %h expected %h", i, mem[8'h40 + i], 32'h1000 + i); end
        end
        checks++; if (mem[8'h44] !== 32'h2000) begin errors++; $display("[TB] FAIL rr_mem_again: got %h expected 2000", mem[8'h44]); end
        @(negedge clk);
    endtask

    task automatic test_single_read();
        mem[8'h10] = 32'hA5;
        set_chan(1, 32'h10, 32'h0);
        req_read[1] = 1'b1;
        @(negedge clk);
        checks++; if ({mem_read, mem_write} !== 2'b10) begin errors++; $display("[TB] FAIL rd_strobe: got %b expected 10", {mem_read, mem_write}); end
        checks++; if (mem_addr !== 32'h10) begin errors++; $display("[TB] FAIL rd_addr: got %h expected 10", mem_addr); end
        checks++; if (grant !== 4'b0010) begin errors++; $display("[TB] FAIL rd_grant: got %b expected 0010", grant); end
        @(negedge clk);
        checks++; if ({mem_read, done} !== 5'b0) begin errors++; $display("[TB] FAIL rd_wait: got %b expected 00000", {mem_read, done}); end
        @(negedge clk);
        // done lands in the fourth cycle counting the request cycle
        checks++; if (done !== 4'b0010) begin errors++; $display("[TB] FAIL rd_done: got %b expected 0010", done); end
        checks++; if (rdata !== 32'hA5) begin errors++; $display("[TB] FAIL rd_data: got %h expected a5", rdata); end
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL rd_err: got %b expected 0", err); end
        req_read[1] = 1'b0;
        @(negedge clk);
        checks++; if ({is_bus_busy, done} !== 5'b0) begin errors++; $display("[TB] FAIL rd_idle: got %b expected 00000", {is_bus_busy, done}); end
    endtask

    task automatic test_hazard();
        set_chan(2, 32'h20, 32'h5A5A);
        set_chan(0, 32'h20, 32'h0);
        req_write[2] = 1'b1;
        req_read[0]  = 1'b1;
        #1;
        checks++; if (rw_halt !== 4'b0001) begin errors++; $display("[TB] FAIL haz_halt: got %b expected 0001", rw_halt); end
        wait_done(20);
        checks++; if (done !== 4'b0100) begin errors++; $display("[TB] FAIL haz_write_first: got %b expected 0100", done); end
        req_write[2] = 1'b0;
        #1;
        checks++; if (rw_halt !== 4'b0000) begin errors++; $display("[TB] FAIL haz_release: got %b expected 0000", rw_halt); end
        wait_done(20);
        checks++; if (done !== 4'b0001) begin errors++; $display("[TB] FAIL haz_read_done: got %b expected 0001", done); end
        checks++; if (rdata !== 32'h5A5A) begin errors++; $display("[TB] FAIL haz_rdata: got %h expected 5a5a", rdata); end
        req_read[0] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_both_rw();
        mem[8'h60] = 32'h0;
        set_chan(3, 32'h60, 32'h77);
        req_write[3] = 1'b1;
        req_read[3]  = 1'b1;
        wait_done(20);
        checks++; if ({done, last_write} !== 5'b10001) begin errors++; $display("[TB] FAIL both_write_first: got %b expected 10001", {done, last_write}); end
        checks++; if (mem[8'h60] !== 32'h77) begin errors++; $display("[TB] FAIL both_mem: got %h expected 77", mem[8'h60]); end
        req_write[3] = 1'b0;
        wait_done(20);
        checks++; if ({done, last_write} !== 5'b10000) begin errors++; $display("[TB] FAIL both_read_next: got %b expected 10000", {done, last_write}); end
        checks++; if (rdata !== 32'h77) begin errors++; $display("[TB] FAIL both_rdata: got %h expected 77", rdata); end
        req_read[3] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_drop();
        set_chan(1, 32'h70, 32'hBEEF);
        req_write[1] = 1'b1;
        @(negedge clk);
        checks++; if (grant !== 4'b0010) begin errors++; $display("[TB] FAIL drop_grant: got %b expected 0010", grant); end
        req_write[1] = 1'b0;
        wait_done(20);
        checks++; if (done !== 4'b0010) begin errors++; $display("[TB] FAIL drop_done: got %b expected 0010", done); end
        checks++; if (mem[8'h70] !== 32'hBEEF) begin errors++; $display("[TB] FAIL drop_mem: got %h expected beef", mem[8'h70]); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        never_ack = 1'b1;
        set_chan(2, 32'h24, 32'hCAFE);
        req_write[2] = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (grant !== 4'b0100) begin errors++; $display("[TB] FAIL mid_grant: got %b expected 0100", grant); end
        rst = 1'b0;
        #1;
        checks++; if ({grant, done} !== 8'b0) begin errors++; $display("[TB] FAIL mid_grant_done: got %b expected 0", {grant, done}); end
        checks++; if ({err, is_bus_busy, mem_read, mem_write} !== 4'b0) begin errors++; $display("[TB] FAIL mid_flags: got %b expected 0000", {err, is_bus_busy, mem_read, mem_write}); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL mid_rdata: got %h expected 0", rdata); end
        checks++; if ({mem_addr, mem_wdata} !== 64'h0) begin errors++; $display("[TB] FAIL mid_bus: got %h expected 0", {mem_addr, mem_wdata}); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (done !== 4'b0) begin errors++; $display("[TB] FAIL mid_no_done_%0d: got %b expected 0000", i, done); end
        end
        req_write = '0;
        never_ack = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        set_chan(0, 32'h28, 32'h11);
        set_chan(3, 32'h2C, 32'h33);
        req_write = 4'b1001;
        @(negedge clk);
        checks++; if (grant !== 4'b0001) begin errors++; $display("[TB] FAIL post_reset_scan: got %b expected 0001", grant); end
        wait_done(20);
        checks++; if (done !== 4'b0001) begin errors++; $display("[TB] FAIL post_reset_done0: got %b expected 0001", done); end
        req_write[0] = 1'b0;
        wait_done(20);
        checks++; if (done !== 4'b1000) begin errors++; $display("[TB] FAIL post_reset_done3: got %b expected 1000", done); end
        req_write[3] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int cyc;
        never_ack = 1'b1;
        set_chan(1, 32'h10, 32'h0);
        req_read[1] = 1'b1;
        @(negedge clk);
        checks++; if (mem_read !== 1'b1) begin errors++; $display("[TB] FAIL tmo_issue: got %b expected 1", mem_read); end
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (done === '0 && cyc < TMO + 20);
        checks++; if (cyc !== TMO + 1) begin errors++; $display("[TB] FAIL tmo_cycles: got %0d expected %0d", cyc, TMO + 1); end
        checks++; if ({done, err} !== 5'b00101) begin errors++; $display("[TB] FAIL tmo_done_err: got %b expected 00101", {done, err}); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL tmo_rdata: got %h expected 0", rdata); end
        req_read[1] = 1'b0;
        @(negedge clk);
        checks++; if ({is_bus_busy, err} !== 2'b00) begin errors++; $display("[TB] FAIL tmo_idle: got %b expected 00", {is_bus_busy, err}); end
        never_ack = 1'b0;
    endtask

    // Scenario sequence; each test leaves the arbiter idle at a falling edge
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        test_reset();
        test_round_robin();
        test_single_read();
        test_hazard();
        test_both_rw();
        test_drop();
        test_reset_mid();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_bus_arbiter.md
REG_BUS_ARBITER -- requirements
Module: reg_bus_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requester channels (register managers).
REQ-002 Parameter ADDR_SIZE, default 32: address width; DATA_SIZE, default 32: data width.
REQ-003 Parameter TMO, default 255: maximum WAIT cycles before timeout.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 req_read  in  N_REQ  per-channel read request, level, held until done.
REQ-007 req_write  in  N_REQ  per-channel write request, level, held until done.
REQ-008 req_addr  in  N_REQ*ADDR_SIZE  per-channel address, channel i at bits [i*ADDR_SIZE +: ADDR_SIZE].
REQ-009 req_wdata  in  N_REQ*DATA_SIZE  per-channel write data, same packing.
REQ-010 grant  out  N_REQ  one-hot owner of the bus, ISSUE through DONE.
REQ-011 done  out  N_REQ  one-cycle completion pulse to owner.
REQ-012 rdata  out  DATA_SIZE  read data, valid while done is high.
REQ-013 err  out  1  one-cycle timeout flag, coincident with done.
REQ-014 rw_halt  out  N_REQ  per-channel read-after-write hazard stall.
REQ-015 is_bus_busy  out  1  high in ISSUE, WAIT, DONE.
REQ-016 mem_addr / mem_wdata  out  ADDR_SIZE / DATA_SIZE  registered bus address and data.
REQ-017 mem_read / mem_write  out  1  one-cycle bus strobes.
REQ-018 mem_ack / mem_rdata  in  1 / DATA_SIZE  bus completion and read data.

Function
REQ-019 FSM states IDLE, ISSUE, WAIT, DONE; IDLE->ISSUE on any eligible request; ISSUE->WAIT always; WAIT->DONE on mem_ack or timeout; DONE->IDLE always.
REQ-020 Eligible: req_write[i], or req_read[i] with rw_halt[i]=0.
REQ-021 rw_halt[i] combinationally high when req_read[i]=1 and some j!=i has req_write[j]=1 with req_addr[j]==req_addr[i].
REQ-022 Winner in IDLE: first eligible channel scanning ptr, ptr+1, ... modulo N_REQ; winner, op, addr, wdata latched on the IDLE->ISSUE edge.
REQ-023 Channel with req_read and req_write both high performs write first; read served on a later grant.
REQ-024 ISSUE: mem_read or mem_write high exactly one cycle, mem_addr/mem_wdata stable from ISSUE to DONE.
REQ-025 WAIT: mem_ack samples mem_rdata into rdata; mem_ack during ISSUE ignored.
REQ-026 Cycle counter cleared on ISSUE, increments in WAIT; count==TMO without mem_ack -> DONE with err=1, rdata=0.
REQ-027 DONE: done[winner]=1, grant held, ptr=(winner+1) mod N_REQ.
REQ-028 Minimum latency request-to-done: 4 cycles with mem_ack on first WAIT cycle.
REQ-029 Requester dropping its request after grant: transaction still completes, done still pulsed.
REQ-030 No eligible request (all reads halted, no writes): FSM stays IDLE, no strobes.

Reset
REQ-031 rst low: immediately state=IDLE, ptr=0, counter=0, grant=0, done=0, err=0, rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, is_bus_busy=0.
REQ-032 rst low mid-transaction aborts; no done pulse issued for the aborted owner.
REQ-033 First arbitration after rst high starts scanning at channel 0.

Verification
REQ-034 Single read ch1 addr 0x10, mem_ack one cycle after mem_read, mem_rdata 0xA5 -> done[1] 4 cycles after request, rdata=0xA5, err=0.
REQ-035 ch0..ch3 all request writes together -> grants in order 0,1,2,3, then new ch0 request served after ch3 (round robin).
REQ-036 ch2 write 0x20 and ch0 read 0x20 concurrently -> rw_halt[0]=1, write ch2 granted first, read ch0 granted after done[2], read returns written value from memory model.
REQ-037 mem_ack never asserted -> done and err high TMO+1 cycles after ISSUE, rdata=0, FSM back in IDLE.
REQ-038 rst low during WAIT -> all outputs zero same cycle, no done; after release ch0 request served normally.
